// File: rtl/eth_rx_deframer_pkg.sv
// Shared constants, FSM state encoding and realign command set for the
// Ethernet RX deframer.
package eth_rx_deframer_pkg;

   localparam int          ETH_HDR_BYTES = 14;
   localparam logic [47:0] MAC_BCAST     = 48'hFFFF_FFFF_FFFF;

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_HDR2,
      S_HDR3,
      S_PAYLOAD,
      S_DROP,
      S_FLUSH
   } state_t;

   // Operations the header FSM asks of the realign/output stage each cycle.
   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_HOLD,   // park in[15:0] (first two payload bytes), no output
      CMD_PASS,   // emit {held, in[31:16]}, park in[15:0]
      CMD_FLUSH,  // emit {held, 16'h0} as the final beat
      CMD_TRUNC   // emit {held, 16'h0} as an errored final beat
   } rcmd_t;

   // Trailing empty count of the extra beat when the last input beat
   // carried three or four valid bytes.
   function automatic logic [1:0] flush_empty(input logic [1:0] in_empty);
      return in_empty + 2'd2;
   endfunction

endpackage

// File: rtl/eth_rx_deframer_if.sv
// Avalon-ST style packet stream (ready latency 0).
interface eth_rx_deframer_if;
   logic [31:0] data;
   logic [1:0]  empty;
   logic        valid;
   logic        sop;
   logic        eop;
   logic        ready;

   modport master (output data, empty, valid, sop, eop, input ready);
   modport slave  (input data, empty, valid, sop, eop, output ready);
endinterface

// File: rtl/eth_rx_deframer_realign.sv
// Payload realignment by two bytes plus the single output register stage.
module eth_rx_deframer_realign
   import eth_rx_deframer_pkg::*;
(
   input  logic        clk_sys_i,
   input  logic        rst_sys_i,
   input  rcmd_t       cmd,
   input  logic [31:0] in_data,
   input  logic        in_eop,
   input  logic [1:0]  in_empty,
   output logic        out_free,
   output logic        err_o,
   eth_rx_deframer_if.master tx
);

   logic [15:0] held;
   logic [1:0]  fl_empty;
   logic        first;

   assign out_free = ~tx.valid | tx.ready;

   // Holding register, pending flush size and output beat register.
   always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
      if (rst_sys_i) begin
         held     <= 16'h0;
         fl_empty <= 2'd0;
         first    <= 1'b0;
         tx.valid <= 1'b0;
         tx.data  <= 32'h0;
         tx.empty <= 2'd0;
         tx.sop   <= 1'b0;
         tx.eop   <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         if (out_free)
            tx.valid <= 1'b0;
         case (cmd)
            CMD_HOLD: begin
               held     <= in_data[15:0];
               fl_empty <= flush_empty(in_empty);
               first    <= 1'b1;
            end
            CMD_PASS: begin
               tx.data  <= {held, in_data[31:16]};
               tx.valid <= 1'b1;
               tx.sop   <= first;
               err_o    <= 1'b0;
               first    <= 1'b0;
               held     <= in_data[15:0];
               fl_empty <= flush_empty(in_empty);
               // Up to two valid bytes fit in this beat; more spill into a flush beat.
               if (in_eop && in_empty >= 2'd2) begin
                  tx.eop   <= 1'b1;
                  tx.empty <= in_empty - 2'd2;
               end else begin
                  tx.eop   <= 1'b0;
                  tx.empty <= 2'd0;
               end
            end
            CMD_FLUSH, CMD_TRUNC: begin
               tx.data  <= {held, 16'h0};
               tx.valid <= 1'b1;
               tx.sop   <= first;
               tx.eop   <= 1'b1;
               tx.empty <= (cmd == CMD_TRUNC) ? 2'd2 : fl_empty;
               err_o    <= (cmd == CMD_TRUNC);
               first    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/eth_rx_deframer.sv
// Ethernet RX deframer: strips the 14-byte MAC header, filters on the
// destination address, captures src/ethertype and counts frames/drops.
module eth_rx_deframer
   import eth_rx_deframer_pkg::*;
#(
   parameter int ACCEPT_BCAST = 1,
   parameter int PROMISC      = 0,
   parameter int CNT_W        = 16
)(
   input  logic             clk_sys_i,
   input  logic             rst_sys_i,
   input  logic [47:0]      mac_local_i,
   eth_rx_deframer_if.slave  rx,
   eth_rx_deframer_if.master tx,
   output logic             err_o,
   output logic [47:0]      mac_src_o,
   output logic [15:0]      ethertype_o,
   output logic             hdr_valid_o,
   output logic [CNT_W-1:0] frame_cnt_o,
   output logic [CNT_W-1:0] drop_cnt_o
);

   state_t      state, state_n;
   rcmd_t       cmd;
   logic        rdy, out_free, dst_ok;
   logic [1:0]  drop_inc;
   logic        fr_inc;
   logic        ld_w0, ld_w1, ld_w2, ld_hdr;
   logic [31:0] w0_q;
   logic [15:0] src_hi;
   logic [31:0] src_lo;
   logic [47:0] dst;

   assign dst      = {w0_q, rx.data[31:16]};
   assign dst_ok   = (PROMISC != 0) || (dst == mac_local_i) ||
                     ((ACCEPT_BCAST != 0) && (dst == MAC_BCAST));
   assign rx.ready = rdy & ~rst_sys_i;
   assign fr_inc   = tx.valid & tx.eop & tx.ready;

   eth_rx_deframer_realign u_realign (
      .clk_sys_i (clk_sys_i),
      .rst_sys_i (rst_sys_i),
      .cmd       (cmd),
      .in_data   (rx.data),
      .in_eop    (rx.eop),
      .in_empty  (rx.empty),
      .out_free  (out_free),
      .err_o     (err_o),
      .tx        (tx)
   );

   // State register and frame/drop counters.
   always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
      if (rst_sys_i) begin
         state       <= S_HDR0;
         frame_cnt_o <= '0;
         drop_cnt_o  <= '0;
      end else begin
         state       <= state_n;
         frame_cnt_o <= frame_cnt_o + CNT_W'(fr_inc);
         drop_cnt_o  <= drop_cnt_o + CNT_W'(drop_inc);
      end
   end

   // Header words held until the frame proves worth reporting.
   always_ff @(posedge clk_sys_i) begin
      if (ld_w0) w0_q   <= rx.data;
      if (ld_w1) src_hi <= rx.data[15:0];
      if (ld_w2) src_lo <= rx.data;
   end

   // Published header of the last accepted frame.
   always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
      if (rst_sys_i) begin
         mac_src_o   <= 48'h0;
         ethertype_o <= 16'h0;
         hdr_valid_o <= 1'b0;
      end else begin
         hdr_valid_o <= ld_hdr;
         if (ld_hdr) begin
            mac_src_o   <= {src_hi, src_lo};
            ethertype_o <= rx.data[31:16];
         end
      end
   end

   // Next state, input ready, realign command and counter increments.
   always_comb begin
      state_n  = state;
      cmd      = CMD_NONE;
      rdy      = out_free;
      drop_inc = 2'd0;
      ld_w0    = 1'b0;
      ld_w1    = 1'b0;
      ld_w2    = 1'b0;
      ld_hdr   = 1'b0;
      case (state)
         S_HDR0: begin
            if (rx.valid && !rx.sop) begin
               rdy = 1'b1;
            end else if (rx.valid && rdy) begin
               if (rx.eop) begin
                  drop_inc = 2'd1;
               end else begin
                  ld_w0   = 1'b1;
                  state_n = S_HDR1;
               end
            end
         end
         S_PAYLOAD: begin
            // A new sop cuts the frame short; it is taken again from HDR0.
            if (rx.valid && rx.sop) begin
               rdy = 1'b0;
               if (out_free) begin
                  cmd     = CMD_TRUNC;
                  state_n = S_HDR0;
               end
            end else if (rx.valid && rdy) begin
               cmd = CMD_PASS;
               if (rx.eop)
                  state_n = (rx.empty >= 2'd2) ? S_HDR0 : S_FLUSH;
            end
         end
         S_FLUSH: begin
            rdy = 1'b0;
            if (out_free) begin
               cmd     = CMD_FLUSH;
               state_n = S_HDR0;
            end
         end
         default: begin
            if (state == S_DROP)
               rdy = 1'b1;
            if (rx.valid && rdy) begin
               if (rx.sop) begin
                  // Current frame is abandoned; a sop+eop beat is itself a runt.
                  drop_inc = rx.eop ? 2'd2 : 2'd1;
                  ld_w0    = ~rx.eop;
                  state_n  = rx.eop ? S_HDR0 : S_HDR1;
               end else if (rx.eop && !(state == S_HDR3 && rx.empty < 2'd2)) begin
                  drop_inc = 2'd1;
                  state_n  = S_HDR0;
               end else begin
                  case (state)
                     S_HDR1: begin
                        ld_w1   = 1'b1;
                        state_n = dst_ok ? S_HDR2 : S_DROP;
                     end
                     S_HDR2: begin
                        ld_w2   = 1'b1;
                        state_n = S_HDR3;
                     end
                     S_HDR3: begin
                        cmd     = CMD_HOLD;
                        ld_hdr  = 1'b1;
                        state_n = rx.eop ? S_FLUSH : S_PAYLOAD;
                     end
                     default: ;
                  endcase
               end
            end
         end
      endcase
   end

endmodule
